btn_conditioner: RTL and testbench

BTN_CONDITIONER -- requirements
Module: btn_conditioner

---
 rtl/btn_conditioner.sv | 161 ++++++++++++++++
 tb/tb_btn_conditioner.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// Button conditioner: per-channel 2-flop sync, debounce, press/release pulses, sticky pending + irq.
// Optional auto-repeat on held buttons is compiled in when BTN_REPEAT_EN is defined.

module btn_chan #(
   parameter int DB_CYCLES     = 16
`ifdef BTN_REPEAT_EN
   ,
   parameter int REPEAT_DELAY  = 1000,
   parameter int REPEAT_PERIOD = 250
`endif
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_i,
   input  logic clr_i,
   output logic level_o,
   output logic press_o,
   output logic release_o,
   output logic pending_o
);
   localparam int CW = $clog2(DB_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

   logic          s1_q, s2_q;
   logic          level_q, level_d;
   logic          press_q, press_d;
   logic          rel_q, rel_d;
   logic          pend_q, pend_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          rise, fall;

   // Any cycle where the synced input agrees with the level restarts the hold count.
   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      if (s2_q != level_q) begin
         if (cnt_q == CNT_MAX) level_d = s2_q;
         else                  cnt_d   = cnt_q + CW'(1);
      end
   end

   assign rise = level_d & ~level_q;
   assign fall = ~level_d & level_q;

`ifdef BTN_REPEAT_EN
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW   = $clog2(RMAX + 1);

   logic [RW-1:0] rcnt_q, rcnt_d, rlim;
   logic          rfirst_q, rfirst_d;
   logic          rpt;

   // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD; a falling edge suppresses firing.
   always_comb begin
      rcnt_d   = rcnt_q;
      rfirst_d = rfirst_q;
      rpt      = 1'b0;
      rlim     = rfirst_q ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1);
      if (!level_d) begin
         rcnt_d   = '0;
         rfirst_d = 1'b0;
      end else if (level_q) begin
         if (rcnt_q == rlim) begin
            rpt      = 1'b1;
            rcnt_d   = '0;
            rfirst_d = 1'b1;
         end else begin
            rcnt_d = rcnt_q + RW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rcnt_q   <= '0;
         rfirst_q <= 1'b0;
      end else begin
         rcnt_q   <= rcnt_d;
         rfirst_q <= rfirst_d;
      end
   end

   assign press_d = rise | rpt;
`else
   assign press_d = rise;
`endif

   assign rel_d  = fall;
   assign pend_d = press_d | (pend_q & ~clr_i);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         rel_q   <= 1'b0;
         pend_q  <= 1'b0;
      end else begin
         s1_q    <= raw_i;
         s2_q    <= s1_q;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         press_q <= press_d;
         rel_q   <= rel_d;
         pend_q  <= pend_d;
      end
   end

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = rel_q;
   assign pending_o = pend_q;
endmodule

module btn_conditioner #(
   parameter int N_BTN         = 5,
   parameter int DB_CYCLES     = 16,
   parameter int REPEAT_DELAY  = 1000,
   parameter int REPEAT_PERIOD = 250
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_raw,
   input  logic [N_BTN-1:0] clr,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release,
   output logic [N_BTN-1:0] btn_pending,
   output logic             irq
);
   if (DB_CYCLES < 2 || DB_CYCLES > 65535) begin : g_bad_db
      $error("btn_conditioner: DB_CYCLES out of range 2..65535");
   end
   if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_rpt
      $error("btn_conditioner: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
   end

   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      btn_chan #(
         .DB_CYCLES    (DB_CYCLES)
`ifdef BTN_REPEAT_EN
         ,
         .REPEAT_DELAY (REPEAT_DELAY),
         .REPEAT_PERIOD(REPEAT_PERIOD)
`endif
      ) u_ch (
         .clk      (clk),
         .rst      (rst),
         .raw_i    (btn_raw[i]),
         .clr_i    (clr[i]),
         .level_o  (btn_level[i]),
         .press_o  (btn_press[i]),
         .release_o(btn_release[i]),
         .pending_o(btn_pending[i])
      );
   end

   assign irq = |btn_pending;
endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner (N_BTN=5, DB_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=4).
// Expected press/release events are queued by the stimulus and popped by a negedge monitor.

module tb_btn_conditioner;
   localparam int N = 5;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] btn_raw, clr;
   logic [N-1:0] btn_level, btn_press, btn_release, btn_pending;
   logic         irq;

   typedef struct {
      int           cyc;
      logic [N-1:0] prs;
      logic [N-1:0] rel;
   } ev_t;

   ev_t q[$];
   int  cyc    = 0;
   int  checks = 0;
   int  errors = 0;

   btn_conditioner #(
      .N_BTN(N), .DB_CYCLES(4), .REPEAT_DELAY(8), .REPEAT_PERIOD(4)
   ) dut (
      .clk(clk), .rst(rst), .btn_raw(btn_raw), .clr(clr),
      .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
      .btn_pending(btn_pending), .irq(irq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chkv(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cyc %0d: got %b expected %b", name, cyc, got, exp);
      end
   endtask

   task automatic chki(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic push(input int c, input logic [N-1:0] p, input logic [N-1:0] r);
      ev_t e;
      e.cyc = c;
      e.prs = p;
      e.rel = r;
      q.push_back(e);
   endtask

   // Stimulus and checks are applied on the negedge where cyc == n.
   task automatic at(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   always @(negedge clk) begin
      ev_t e;
      if ((btn_press | btn_release) != '0) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event cyc %0d: press %b release %b expected none",
                     cyc, btn_press, btn_release);
         end else begin
            e = q.pop_front();
            chki("ev_cycle", cyc, e.cyc);
            chkv("ev_press", btn_press, e.prs);
            chkv("ev_release", btn_release, e.rel);
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: bench still running at cyc %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      rst     = 1'b1;
      btn_raw = 5'b00100;
      clr     = '0;

      // Reset holds everything at zero even with a button pressed.
      at(10);
      chkv("rst_level",   btn_level,   '0);
      chkv("rst_press",   btn_press,   '0);
      chkv("rst_release", btn_release, '0);
      chkv("rst_pending", btn_pending, '0);
      chkv("rst_irq",     N'(irq),     '0);

      // Button held through reset release: press six edges later.
      at(30); rst = 1'b0;
      push(36, 5'b00100, '0);
      at(35); chkv("a_level_pre", btn_level, '0);
      at(36); chkv("a_level",     btn_level, 5'b00100);
      at(37);
      chkv("a_pending", btn_pending, 5'b00100);
      chkv("a_irq",     N'(irq),     5'd1);
      btn_raw[2] = 1'b0;
      push(43, '0, 5'b00100);
      at(43);
      chkv("a_level_fall", btn_level,   '0);
      chkv("a_pend_keep",  btn_pending, 5'b00100);

      // Short glitch on channel 0 is filtered.
      at(50); btn_raw[0] = 1'b1;
      at(53); btn_raw[0] = 1'b0;
      at(62);
      chkv("b_level",   btn_level,   '0);
      chkv("b_pending", btn_pending, 5'b00100);

      // Clear pending; clr on an idle channel does nothing.
      clr = 5'b00101;
      at(63); clr = '0;
      chkv("c_pend_clr", btn_pending, '0);
      chkv("c_irq",      N'(irq),     '0);

      // clr coincident with the press edge: set wins.
      at(64); btn_raw[3] = 1'b1;
      push(70, 5'b01000, '0);
      at(69); clr = 5'b01000;
      at(70); clr = '0; btn_raw[3] = 1'b0;
      push(76, '0, 5'b01000);
      at(71); chkv("c_set_wins", btn_pending, 5'b01000);
      at(77); clr = 5'b01000;
      at(78); clr = '0;
      chkv("c_pend_clr3", btn_pending, '0);

      // Bouncing channel 1: single press 6 edges after the last transition.
      for (int k = 0; k < 5; k++) begin
         at(80 + 2 * k);
         btn_raw[1] = (k % 2 == 0);
      end
      push(94, 5'b00010, '0);
      at(94); btn_raw[1] = 1'b0;
      push(100, '0, 5'b00010);
      at(95); chkv("d_pending", btn_pending, 5'b00010);
      at(101); clr = 5'b00010;
      at(102); clr = '0;
      chkv("d_pend_clr", btn_pending, '0);

      // Two channels at once.
      at(104); btn_raw = 5'b10001;
      push(110, 5'b10001, '0);
      at(110); btn_raw = '0;
      push(116, '0, 5'b10001);
      at(111);
      chkv("e_level_multi", btn_level,   5'b10001);
      chkv("e_pend_multi",  btn_pending, 5'b10001);
      at(117); clr = '1;
      at(118); clr = '0;
      chkv("e_pend_clr", btn_pending, '0);

      // Reset mid-debounce clears outputs asynchronously and discards counts.
      at(120); btn_raw[3] = 1'b1;
      push(126, 5'b01000, '0);
      at(128); btn_raw[0] = 1'b1;
      at(130); chkv("f_level_before", btn_level, 5'b01000);
      at(131); rst = 1'b1;
      #1;
      chkv("f_async_level",   btn_level,   '0);
      chkv("f_async_pending", btn_pending, '0);
      chkv("f_async_press",   btn_press,   '0);
      chkv("f_async_irq",     N'(irq),     '0);
      at(133); rst = 1'b0;
      push(139, 5'b01001, '0);
      at(138); chkv("f_level_pre", btn_level, '0);
      at(139); btn_raw = '0;
      push(145, '0, 5'b01001);
      at(140); chkv("f_pending", btn_pending, 5'b01001);
      at(146); clr = '1;
      at(147); clr = '0;

      // Long hold on channel 4: repeats only when compiled in, none on the release edge.
      at(150); btn_raw[4] = 1'b1;
      push(156, 5'b10000, '0);
`ifdef BTN_REPEAT_EN
      for (int t = 164; t < 196; t += 4) push(t, 5'b10000, '0);
`endif
      at(190); btn_raw[4] = 1'b0;
      push(196, '0, 5'b10000);
      at(197); chkv("g_pending", btn_pending, 5'b10000);

      at(205);
      chki("events_left", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
